nbody_mm_slave: RTL

//  Memory-mapped responder terminating the host's 64-bit chipselect/read/write bus for the n-body accelerator.

---
 rtl/nbody_mm_slave.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/nbody_mm_slave.sv
// nbody_mm_slave: 64-bit chipselect/read/write bus responder for the n-body accelerator.
// Ports: clk, rst (async active-low), bus (chipselect/read/write/addr/writedata/readdata),
//   body RAM port (body_we/sel/idx/wdata, body_rdata), n_bodies, gap, go/core_done/busy.
module nbody_mm_slave #(
    parameter int ADDR_WIDTH      = 16,
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chipselect,
    input  logic                       read,
    input  logic                       write,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [DATA_WIDTH-1:0]      writedata,
    output logic [DATA_WIDTH-1:0]      readdata,
    output logic                       body_we,
    output logic [2:0]                 body_sel,
    output logic [BODY_ADDR_WIDTH-1:0] body_idx,
    output logic [DATA_WIDTH-1:0]      body_wdata,
    input  logic [DATA_WIDTH-1:0]      body_rdata,
    output logic [BODY_ADDR_WIDTH:0]   n_bodies,
    output logic [31:0]                gap,
    output logic                       go,
    input  logic                       core_done,
    output logic                       busy
);

    localparam int SW         = ADDR_WIDTH - BODY_ADDR_WIDTH;
    localparam int MAX_BODIES = 2 ** BODY_ADDR_WIDTH;

    localparam logic [SW-1:0] SEL_GO     = SW'(7'h00);
    localparam logic [SW-1:0] SEL_N      = SW'(7'h02);
    localparam logic [SW-1:0] SEL_X      = SW'(7'h03);
    localparam logic [SW-1:0] SEL_VY     = SW'(7'h07);
    localparam logic [SW-1:0] SEL_GAP    = SW'(7'h08);
    localparam logic [SW-1:0] SEL_STATUS = SW'(7'h40);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;
    logic   go_n;

    logic [SW-1:0]              sel;
    logic [BODY_ADDR_WIDTH-1:0] idx;
    logic                       wr_acc;
    logic                       rd_acc;
    logic                       is_arr;
    logic [2:0]                 arr_field;
    logic                       in_run;
    logic                       cfg_wr;
    logic                       cfg_ok;
    logic                       cfg_drop;
    logic                       go_req;
    logic                       go_ok;
    logic                       go_ref;
    logic                       port_hit;

    logic [2:0]                 sel_q;
    logic [BODY_ADDR_WIDTH-1:0] idx_q;
    logic [15:0]                ign_cnt;

    logic                       rd_v1;
    logic                       rd_arr1;
    logic [DATA_WIDTH-1:0]      rd_val1;
    logic [DATA_WIDTH-1:0]      reg_val;
    logic [DATA_WIDTH-1:0]      status_val;

    // ---------------- decode ----------------
    assign sel       = addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH];
    assign idx       = addr[BODY_ADDR_WIDTH-1:0];
    assign wr_acc    = chipselect & write;
    assign rd_acc    = chipselect & read;
    assign is_arr    = (sel >= SEL_X) && (sel <= SEL_VY);
    assign arr_field = sel[2:0] - 3'd3;
    assign in_run    = (state == S_RUN);

    // Writes that change configuration or body data; locked out while running.
    assign cfg_wr   = wr_acc & (is_arr | (sel == SEL_N) | (sel == SEL_GAP));
    assign cfg_ok   = cfg_wr & ~in_run;
    assign cfg_drop = cfg_wr & in_run;

    assign go_req = wr_acc & (sel == SEL_GO) & writedata[0];
    assign go_ok  = go_req & ~in_run
                  & (n_bodies >= (BODY_ADDR_WIDTH+1)'(2));
    assign go_ref = go_req & ~go_ok;

    // ---------------- body RAM port ----------------
    assign port_hit   = chipselect & (read | write) & is_arr;
    assign body_we    = rst & cfg_ok & is_arr;
    assign body_sel   = port_hit ? arr_field : sel_q;
    assign body_idx   = port_hit ? idx : idx_q;
    assign body_wdata = writedata;

    // Last presented address is held while the bus is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= '0;
            idx_q <= '0;
        end else if (port_hit) begin
            sel_q <= arr_field;
            idx_q <= idx;
        end
    end

    // ---------------- run state machine ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            go    <= 1'b0;
        end else begin
            state <= state_n;
            go    <= go_n;
        end
    end

    always_comb begin
        state_n = state;
        go_n    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go_ok) begin
                    state_n = S_RUN;
                    go_n    = 1'b1;
                end
            end
            S_RUN: begin
                if (core_done) state_n = S_DONE;
            end
            S_DONE: begin
                if (go_ok) begin
                    state_n = S_RUN;
                    go_n    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = in_run;

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_bodies <= '0;
            gap      <= '0;
        end else if (cfg_ok) begin
            if (sel == SEL_N) begin
                if (writedata > DATA_WIDTH'(MAX_BODIES))
                    n_bodies <= (BODY_ADDR_WIDTH+1)'(MAX_BODIES);
                else
                    n_bodies <= writedata[BODY_ADDR_WIDTH:0];
            end else if (sel == SEL_GAP) begin
                gap <= writedata[31:0];
            end
        end
    end

    // Refused GOs and locked-out writes are counted, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ign_cnt <= '0;
        end else if ((cfg_drop | go_ref) && (ign_cnt != 16'hFFFF)) begin
            ign_cnt <= ign_cnt + 16'd1;
        end
    end

    // ---------------- read pipeline ----------------
    assign status_val = {32'b0, ign_cnt, 13'b0, state, (state == S_DONE)};

    // A read sharing a cycle with a write returns zero.
    always_comb begin
        reg_val = '0;
        if (!wr_acc) begin
            if (sel == SEL_N)
                reg_val = DATA_WIDTH'(n_bodies);
            else if (sel == SEL_GAP)
                reg_val = DATA_WIDTH'(gap);
            else if (sel == SEL_STATUS)
                reg_val = status_val;
        end
    end

    // Stage 1 lines up with the RAM's synchronous read; stage 2 is readdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_v1    <= 1'b0;
            rd_arr1  <= 1'b0;
            rd_val1  <= '0;
            readdata <= '0;
        end else begin
            rd_v1   <= rd_acc;
            rd_arr1 <= rd_acc & is_arr & ~wr_acc;
            rd_val1 <= reg_val;
            if (rd_v1)
                readdata <= rd_arr1 ? body_rdata : rd_val1;
        end
    end

endmodule
